// File: rtl/rr_arbiter_16.sv
// 16-requester round-robin arbiter with a registered one-hot grant and valid/ready handshake.
// Optional build macro RR_ARB_LOCK_EN adds a 'lock' input that re-grants the current winner.
module rr_arbiter_16 #(
  parameter int N  = 16,
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
`ifdef RR_ARB_LOCK_EN
  input  logic          lock,
`endif
  input  logic          gnt_ready,
  output logic [N-1:0]  gnt,
  output logic          gnt_valid,
  output logic [PW-1:0] ptr
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  logic          r_state;
  logic [N-1:0]  r_gnt;
  logic          r_gnt_valid;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_winner;

  logic          w_lock_hold;
  logic [PW-1:0] w_base;
  logic [N-1:0]  w_req_rot;
  logic          w_found;
  logic [PW-1:0] w_off;
  logic [PW-1:0] w_win;

`ifdef RR_ARB_LOCK_EN
  assign w_lock_hold = lock & req[r_winner];
`else
  assign w_lock_hold = 1'b0;
`endif

  // Search start: the pointer when idle, otherwise the pointer value a handshake would produce.
  always_comb begin
    if (r_state == ST_IDLE) begin
      w_base = r_ptr;
    end else if (w_lock_hold) begin
      w_base = r_winner;
    end else begin
      w_base = r_winner + PW'(1);
    end
  end

  // Rotate requests so bit 0 is the highest-priority requester; index arithmetic wraps mod 16.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rot
      assign w_req_rot[gi] = req[PW'(gi) + w_base];
    end
  endgenerate

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_req_rot[i]) begin
        w_found = 1'b1;
        w_off   = PW'(i);
      end
    end
  end

  assign w_win = w_base + w_off;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_ptr       <= '0;
      r_winner    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_gnt       <= N'(1) << w_win;
            r_gnt_valid <= 1'b1;
            r_winner    <= w_win;
            r_state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // Without ready the grant is frozen regardless of req.
          if (gnt_ready) begin
            if (!w_lock_hold) begin
              r_ptr <= r_winner + PW'(1);
            end
            if (w_found) begin
              r_gnt       <= N'(1) << w_win;
              r_gnt_valid <= 1'b1;
              r_winner    <= w_win;
            end else begin
              r_gnt       <= '0;
              r_gnt_valid <= 1'b0;
              r_state     <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_gnt       <= '0;
          r_gnt_valid <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = r_gnt_valid;
  assign ptr       = r_ptr;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Testbench for rr_arbiter_16: directed scenarios plus random traffic against a behavioural model.
module tb_rr_arbiter_16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] req = '0;
  logic        gnt_ready = 1'b0;
  logic        lock_drv = 1'b0;
  logic [15:0] gnt;
  logic        gnt_valid;
  logic [3:0]  ptr;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: pointer, winner index, valid flag.
  int m_ptr   = 0;
  int m_w     = 0;
  bit m_valid = 0;

  rr_arbiter_16 dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
`ifdef RR_ARB_LOCK_EN
    .lock      (lock_drv),
`endif
    .gnt_ready (gnt_ready),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .ptr       (ptr)
  );

  always #5 clk = ~clk;

  function automatic int search(logic [15:0] r, int p);
    for (int k = 0; k < 16; k++) begin
      if (r[(p + k) % 16]) return (p + k) % 16;
    end
    return -1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clock(logic [15:0] r, logic rdy, logic lk);
    int s;
    if (!m_valid) begin
      s = search(r, m_ptr);
      if (s >= 0) begin
        m_valid = 1;
        m_w     = s;
      end
    end else if (rdy) begin
      if (!(lk && r[m_w])) begin
        m_ptr = (m_w + 1) % 16;
        s = search(r, m_ptr);
        if (s >= 0) m_w = s;
        else m_valid = 0;
      end
    end
  endtask

  task automatic check_model(string tag);
    logic [15:0] eg;
    eg = m_valid ? (16'h1 << m_w) : 16'h0;
    chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
    chk({tag, "_valid"}, 32'(gnt_valid), 32'(m_valid));
    chk({tag, "_ptr"}, 32'(ptr), 32'(m_ptr));
    chk({tag, "_onehot"}, 32'(gnt_valid ? $countones(gnt) : 1), 32'd1);
  endtask

  // Called at posedge+1 with inputs already driven; ends at the next posedge+1.
  task automatic step(string tag, logic [15:0] r, logic rdy, logic lk);
    req       = r;
    gnt_ready = rdy;
    lock_drv  = lk;
    @(posedge clk);
    model_clock(r, rdy, lk);
    #1;
    check_model(tag);
    $display("%s req=%h rdy=%0b lock=%0b -> gnt=%h valid=%0b ptr=%0d",
             tag, r, rdy, lk, gnt, gnt_valid, ptr);
  endtask

  // Asserts reset between clock edges and checks outputs clear before the next edge.
  task automatic do_reset(string tag);
    #3;
    rst = 1'b1;
    #1;
    chk({tag, "_rst_gnt"}, 32'(gnt), 32'h0);
    chk({tag, "_rst_valid"}, 32'(gnt_valid), 32'h0);
    chk({tag, "_rst_ptr"}, 32'(ptr), 32'h0);
    m_ptr = 0; m_w = 0; m_valid = 0;
    req = '0; gnt_ready = 1'b0; lock_drv = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    $display("%s reset applied", tag);
  endtask

  initial begin
    #2;
    chk("init_gnt", 32'(gnt), 32'h0);
    chk("init_valid", 32'(gnt_valid), 32'h0);
    chk("init_ptr", 32'(ptr), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single request, then handshake with nothing pending.
    step("single_a", 16'h0020, 1'b1, 1'b0);
    chk("single_gnt", 32'(gnt), 32'h0020);
    step("single_b", 16'h0000, 1'b1, 1'b0);
    chk("single_ptr", 32'(ptr), 32'd6);
    chk("single_idle", 32'(gnt_valid), 32'h0);

    // Mid-grant asynchronous reset.
    step("pre_rst", 16'h0100, 1'b0, 1'b0);
    chk("pre_rst_valid", 32'(gnt_valid), 32'h1);
    do_reset("midgrant");

    // Backpressure: grant held while requester 0 drops its request.
    step("bp_0", 16'h8001, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step("bp_hold", (i < 2) ? 16'h8001 : 16'h8000, 1'b0, 1'b0);
      chk("bp_stable", 32'(gnt), 32'h0001);
    end
    step("bp_release", 16'h8000, 1'b1, 1'b0);
    chk("bp_next_gnt", 32'(gnt), 32'h8000);
    chk("bp_ptr", 32'(ptr), 32'd1);

    // Wrap-around from pointer 14.
    do_reset("wrap");
    step("wrap_prep_a", 16'h2000, 1'b1, 1'b0);
    step("wrap_prep_b", 16'h0000, 1'b1, 1'b0);
    chk("wrap_ptr14", 32'(ptr), 32'd14);
    step("wrap_a", 16'h0003, 1'b1, 1'b0);
    chk("wrap_gnt0", 32'(gnt), 32'h0001);
    step("wrap_b", 16'h0003, 1'b1, 1'b0);
    chk("wrap_gnt1", 32'(gnt), 32'h0002);
    chk("wrap_ptr1", 32'(ptr), 32'd1);
    step("wrap_c", 16'h0000, 1'b1, 1'b0);
    chk("wrap_ptr2", 32'(ptr), 32'd2);

    // Fairness: everyone requesting, grant walks 0..15 twice.
    do_reset("fair");
    for (int i = 0; i < 32; i++) begin
      step("fair", 16'hFFFF, 1'b1, 1'b0);
      chk("fair_order", 32'(gnt), 32'(16'h1 << (i % 16)));
    end

`ifdef RR_ARB_LOCK_EN
    do_reset("lock");
    step("lock_first", 16'h0104, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step("lock_hold", 16'h0104, 1'b1, 1'b1);
      chk("lock_same", 32'(gnt), 32'h0004);
    end
    step("lock_drop", 16'h0104, 1'b1, 1'b0);
    chk("lock_next", 32'(gnt), 32'h0100);
`endif

    // Random traffic against the model.
    do_reset("rand");
    for (int i = 0; i < 300; i++) begin
      logic [15:0] r;
      logic rdy;
      logic lk;
      case ($urandom_range(0, 3))
        0: r = 16'h0;
        1: r = 16'h1 << $urandom_range(0, 15);
        default: r = 16'($urandom);
      endcase
      rdy = 1'($urandom_range(0, 2) != 0);
`ifdef RR_ARB_LOCK_EN
      lk = 1'($urandom_range(0, 3) == 0);
`else
      lk = 1'b0;
`endif
      step("rand", r, rdy, lk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rr_arbiter_16.md
Name: rr_arbiter_16

Overview:
- 16-requester round-robin arbiter with a registered one-hot grant and a valid/ready output handshake.
- Sits directly upstream of the 16-to-4 one-hot encoder: `gnt` drives the encoder's 16-bit `d` input.
- Guarantee: `gnt` is always exactly one-hot while `gnt_valid`=1 and all-zero otherwise, so the encoder never sees a multi-hot or ambiguous pattern.

Parameters:
- N, 16, number of requesters. Fixed at 16 for this block; other values are unsupported.
- PW, 4, pointer width, log2(N).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  16  request vector; bit i = requester i wants service. Level-sensitive.
- gnt_ready  input  1  downstream accepts the current grant.
- gnt  output  16  registered one-hot grant; 16'b0 when no grant is valid.
- gnt_valid  output  1  `gnt` holds a valid grant.
- ptr  output  4  current round-robin priority pointer, for debug and verification.

Behaviour:
- Reset (async, rst=1): `gnt`=16'b0, `gnt_valid`=0, `ptr`=4'd0, FSM in IDLE. All take effect immediately, independent of `clk`. Reset mid-grant discards the grant; no handshake is reported.
- FSM states: IDLE and GRANT.
- IDLE:
  - If `req`==0: stay in IDLE, outputs unchanged (`gnt`=0, `gnt_valid`=0).
  - If `req`!=0: the winner is the first set bit searching upward from index `ptr` with wrap (`ptr`, `ptr`+1, ..., 15, 0, ..., `ptr`-1).
  - Next edge: `gnt`=1<<winner, `gnt_valid`=1, go to GRANT.
  - Latency: request visible in cycle t gives a grant visible in cycle t+1.
- GRANT:
  - While `gnt_ready`=0: `gnt` and `gnt_valid` hold stable. Changes on `req`, including the winner dropping its request, are ignored; a grant is never retracted.
  - Handshake (`gnt_valid`=1 and `gnt_ready`=1 at a rising edge): `ptr` <= (winner+1) mod 16, wrapping 15 to 0.
  - In the same edge, re-arbitrate on the `req` sampled that cycle, using the NEW pointer value.
  - If any request is found: load the new one-hot `gnt`, keep `gnt_valid`=1, stay in GRANT. Back-to-back grants at one per cycle.
  - If none: `gnt`=0, `gnt_valid`=0, go to IDLE.
- `ptr` changes only on a handshake, never on a plain arbitration.
- Fairness: with all 16 requesting continuously and `gnt_ready`=1, the grant order is 0,1,...,15,0,... Each requester waits at most 15 handshakes.
- Invariants:
  - `gnt_valid`=1 implies popcount(`gnt`)=1.
  - `gnt_valid`=0 implies `gnt`=0.
  - `gnt_ready` is ignored when `gnt_valid`=0.
- Purely synchronous datapath apart from the async reset. No combinational path from `req` or `gnt_ready` to any output.

Optional Feature:
- Macro: RR_ARB_LOCK_EN.
- Defined:
  - Adds input port `lock` (1 bit).
  - If `lock`=1 at a handshake and the current winner's `req` bit is still 1: `ptr` is not advanced and the same requester is re-granted next cycle. This supports multi-beat transfers.
  - If the winner's `req` bit is 0, `lock` is ignored and normal rotation applies.
- Not defined: no `lock` port; every handshake advances `ptr` as described above.

Test Plan:
- Reset: assert `rst` asynchronously mid-cycle with `gnt_valid`=1 → `gnt`=0, `gnt_valid`=0, `ptr`=0 immediately, without waiting for a clock edge.
- Single request: `req`=16'h0020, `gnt_ready`=1 → next cycle `gnt`=16'h0020, `gnt_valid`=1; after the handshake, `ptr`=6; with `req`=0, `gnt_valid`=0 the following cycle.
- Backpressure: `req`=16'h8001, `ptr`=0, `gnt_ready`=0 for 5 cycles → `gnt`=16'h0001 held stable all 5 cycles, even after `req` bit 0 drops; raise `gnt_ready` → handshake, then `gnt`=16'h8000, `ptr`=1.
- Wrap-around: `ptr`=14 (prepared via handshakes), `req`=16'h0003 → `gnt`=16'h0001, then `gnt`=16'h0002 back-to-back with `gnt_ready`=1; `ptr` sequence 1, then 2.
- Fairness: `req`=16'hFFFF, `gnt_ready`=1 for 32 cycles → `gnt` walks 16'h0001 through 16'h8000 twice. Each grant is one-hot, checked by assertion every cycle.
- With RR_ARB_LOCK_EN defined: `req`=16'h0104, `lock`=1 for 3 handshakes → `gnt`=16'h0004 for all three; drop `lock` → next grant is `gnt`=16'h0100.
